state_led_driver: RTL and testbench



---
 rtl/state_led_driver_if.sv | 25 ++
 rtl/state_led_driver.sv | 116 +++++++++++
 tb/tb_state_led_driver.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/state_led_driver_if.sv
// Signal bundle between the calculator control FSM/ALU and the LED driver.
// The master drives state/opcode/result/error; the slave returns the LED drive.
interface state_led_driver_if #(
    parameter int STATE_W = 2,
    parameter int OP_W    = 2,
    parameter int DATA_W  = 16,
    parameter int LED_W   = 16
);
    logic [STATE_W-1:0] c_state;
    logic [OP_W-1:0]    OpCode;
    logic [DATA_W-1:0]  result;
    logic               error;
    logic [LED_W-1:0]   LED;
    logic               blinking;

    modport master (
        output c_state, OpCode, result, error,
        input  LED, blinking
    );

    modport slave (
        input  c_state, OpCode, result, error,
        output LED, blinking
    );
endinterface

// File: rtl/state_led_driver.sv
// Registered LED driver: thermometer progress bar per FSM state, ALU result or
// full bar in the final state, and a fixed-rate full-bar blink on ALU error.
module state_led_driver #(
    parameter int                   N_STATES       = 4,
    parameter int                   STATE_W        = 2,
    parameter int                   OP_W           = 2,
    parameter int                   DATA_W         = 16,
    parameter int                   LED_W          = 16,
    parameter logic [2**OP_W-1:0]   RESULT_OP_MASK = 4'b1100,
    parameter int                   BLINK_DIV      = 25_000_000
) (
    input  logic              clk,
    input  logic              reset,
    state_led_driver_if.slave bus
);
    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    typedef enum logic {
        PHASE_OFF = 1'b0,
        PHASE_ON  = 1'b1
    } phase_t;

    logic [CNT_W-1:0]   counter_q, counter_d;
    phase_t             phase_q, phase_d;
    logic [STATE_W-1:0] prevState_q;
    logic               errorPrev_q;
    logic [LED_W-1:0]   led_q, led_d;
    logic               blinking_q, blinking_d;

    logic [31:0]      stateIdx;
    logic             isFinal;
    logic             inRange;
    logic             blinkActive;
    logic             restart;
    logic [LED_W-1:0] resultMapped;
    logic [LED_W-1:0] thermo;
    logic [LED_W-1:0] fullBar;
    logic [LED_W-1:0] pattern;

    // Widen the state so range checks stay meaningful when 2**STATE_W == N_STATES.
    assign stateIdx = 32'(bus.c_state);
    assign isFinal  = (stateIdx == 32'(N_STATES - 1));
    assign inRange  = (stateIdx < 32'(N_STATES));

    generate
        if (DATA_W > LED_W) begin : g_resultTrunc
            logic unusedResultBits;
            assign unusedResultBits = ^bus.result[DATA_W-1:LED_W];
            assign resultMapped     = bus.result[LED_W-1:0];
        end else if (DATA_W == LED_W) begin : g_resultSame
            assign resultMapped = bus.result;
        end else begin : g_resultExt
            assign resultMapped = {{(LED_W - DATA_W){1'b0}}, bus.result};
        end
    endgenerate

    always_comb begin
        thermo  = '0;
        fullBar = '0;
        for (int i = 0; i < LED_W; i++) begin
            thermo[i]  = (32'(i) <= stateIdx);
            fullBar[i] = (32'(i) < 32'(N_STATES));
        end
        pattern = '0;
        if (isFinal) begin
            pattern = RESULT_OP_MASK[bus.OpCode] ? resultMapped : fullBar;
        end else if (inRange) begin
            pattern = thermo;
        end
    end

    // A state change and an error rise on the same edge collapse into one restart.
    always_comb begin
        blinkActive = isFinal && bus.error;
        restart     = (bus.c_state != prevState_q) ||
                      (isFinal && bus.error && !errorPrev_q);
        counter_d   = '0;
        phase_d     = PHASE_ON;
        if (blinkActive && !restart) begin
            if (counter_q == CNT_LAST) begin
                counter_d = '0;
                phase_d   = (phase_q == PHASE_ON) ? PHASE_OFF : PHASE_ON;
            end else begin
                counter_d = counter_q + CNT_W'(1);
                phase_d   = phase_q;
            end
        end
        led_d      = pattern;
        if (blinkActive) begin
            led_d = (phase_d == PHASE_ON) ? {LED_W{1'b1}} : {LED_W{1'b0}};
        end
        blinking_d = blinkActive;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter_q   <= '0;
            phase_q     <= PHASE_ON;
            prevState_q <= '0;
            errorPrev_q <= 1'b0;
            led_q       <= '0;
            blinking_q  <= 1'b0;
        end else begin
            counter_q   <= counter_d;
            phase_q     <= phase_d;
            prevState_q <= bus.c_state;
            errorPrev_q <= bus.error;
            led_q       <= led_d;
            blinking_q  <= blinking_d;
        end
    end

    assign bus.LED      = led_q;
    assign bus.blinking = blinking_q;
endmodule

// File: tb/tb_state_led_driver.sv
// Bench for state_led_driver: a 4-state/16-LED instance and a 6-state/8-LED
// instance, both with a short blink period, checked through a scoreboard queue.
module tb_state_led_driver;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    state_led_driver_if #(.STATE_W(2), .OP_W(2), .DATA_W(16), .LED_W(16)) busA ();
    state_led_driver_if #(.STATE_W(3), .OP_W(2), .DATA_W(12), .LED_W(8))  busB ();

    state_led_driver #(
        .N_STATES(4), .STATE_W(2), .OP_W(2), .DATA_W(16), .LED_W(16),
        .RESULT_OP_MASK(4'b1100), .BLINK_DIV(4)
    ) dutA (
        .clk(clk),
        .reset(reset),
        .bus(busA)
    );

    state_led_driver #(
        .N_STATES(6), .STATE_W(3), .OP_W(2), .DATA_W(12), .LED_W(8),
        .RESULT_OP_MASK(4'b1100), .BLINK_DIV(4)
    ) dutB (
        .clk(clk),
        .reset(reset),
        .bus(busB)
    );

    typedef struct {
        string       name;
        logic [15:0] led;
        logic        blink;
        bit          useB;
    } exp_t;

    typedef struct {
        string       name;
        logic [1:0]  st;
        logic [1:0]  op;
        logic [15:0] res;
        logic        err;
        logic [15:0] expLed;
        logic        expBlink;
    } vec_t;

    exp_t sbQ[$];
    vec_t vecs[$];
    int   testsRun    = 0;
    int   testsFailed = 0;

    task automatic checkOutput();
        exp_t        e;
        logic [15:0] actLed;
        logic        actBlink;
        testsRun++;
        if (sbQ.size() == 0) begin
            testsFailed++;
            $display("[TB] FAIL scoreboard: queue empty, one pending expectation required");
            return;
        end
        e = sbQ.pop_front();
        if (e.useB) begin
            actLed   = {8'h00, busB.LED};
            actBlink = busB.blinking;
        end else begin
            actLed   = busA.LED;
            actBlink = busA.blinking;
        end
        if (actLed !== e.led || actBlink !== e.blink) begin
            testsFailed++;
            $display("[TB] FAIL %s: LED=%h blinking=%b, expected LED=%h blinking=%b",
                     e.name, actLed, actBlink, e.led, e.blink);
        end
    endtask

    task automatic applyStimulus(input string name, input bit useB,
                                 input logic [2:0] st, input logic [1:0] op,
                                 input logic [15:0] res, input logic err,
                                 input logic [15:0] expLed, input logic expBlink);
        @(negedge clk);
        if (useB) begin
            busB.c_state = st;
            busB.OpCode  = op;
            busB.result  = res[11:0];
            busB.error   = err;
        end else begin
            busA.c_state = st[1:0];
            busA.OpCode  = op;
            busA.result  = res;
            busA.error   = err;
        end
        sbQ.push_back('{name: name, led: expLed, blink: expBlink, useB: useB});
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        reset        = 1'b1;
        busA.c_state = '0;
        busA.OpCode  = '0;
        busA.result  = '0;
        busA.error   = 1'b0;
        busB.c_state = '0;
        busB.OpCode  = '0;
        busB.result  = '0;
        busB.error   = 1'b0;

        vecs.push_back('{"state0",      2'd0, 2'd0, 16'h0000, 1'b0, 16'h0001, 1'b0});
        vecs.push_back('{"state1",      2'd1, 2'd0, 16'h0000, 1'b0, 16'h0003, 1'b0});
        vecs.push_back('{"state2",      2'd2, 2'd0, 16'h0000, 1'b0, 16'h0007, 1'b0});
        vecs.push_back('{"finalOp2",    2'd3, 2'd2, 16'hBEEF, 1'b0, 16'hBEEF, 1'b0});
        vecs.push_back('{"finalOp1Bar", 2'd3, 2'd1, 16'hBEEF, 1'b0, 16'h000F, 1'b0});
        vecs.push_back('{"finalOp3",    2'd3, 2'd3, 16'h1234, 1'b0, 16'h1234, 1'b0});
        vecs.push_back('{"resultChg",   2'd3, 2'd3, 16'h5678, 1'b0, 16'h5678, 1'b0});
        vecs.push_back('{"finalOp0Bar", 2'd3, 2'd0, 16'h5678, 1'b0, 16'h000F, 1'b0});
        vecs.push_back('{"backTo2",     2'd2, 2'd0, 16'h5678, 1'b0, 16'h0007, 1'b0});

        #12;
        sbQ.push_back('{name: "resetA", led: 16'h0000, blink: 1'b0, useB: 1'b0});
        checkOutput();
        sbQ.push_back('{name: "resetB", led: 16'h0000, blink: 1'b0, useB: 1'b1});
        checkOutput();
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].name, 1'b0, {1'b0, vecs[i].st}, vecs[i].op,
                          vecs[i].res, vecs[i].err, vecs[i].expLed, vecs[i].expBlink);
        end

        // Entry from state 2: on/off/on, four cycles each.
        for (int c = 0; c < 12; c++) begin
            applyStimulus($sformatf("blink%0d", c), 1'b0, 3'd3, 2'd2, 16'hBEEF, 1'b1,
                          ((c / 4) % 2 == 0) ? 16'hFFFF : 16'h0000, 1'b1);
        end
        applyStimulus("errorDrop", 1'b0, 3'd3, 2'd2, 16'hBEEF, 1'b0, 16'hBEEF, 1'b0);

        for (int c = 0; c < 6; c++) begin
            applyStimulus($sformatf("errRise%0d", c), 1'b0, 3'd3, 2'd2, 16'hBEEF, 1'b1,
                          (c < 4) ? 16'hFFFF : 16'h0000, 1'b1);
        end
        applyStimulus("leaveFinal", 1'b0, 3'd2, 2'd2, 16'hBEEF, 1'b1, 16'h0007, 1'b0);
        for (int c = 0; c < 5; c++) begin
            applyStimulus($sformatf("reenter%0d", c), 1'b0, 3'd3, 2'd2, 16'hBEEF, 1'b1,
                          (c < 4) ? 16'hFFFF : 16'h0000, 1'b1);
        end

        applyStimulus("preSimul", 1'b0, 3'd2, 2'd2, 16'hBEEF, 1'b0, 16'h0007, 1'b0);
        for (int c = 0; c < 5; c++) begin
            applyStimulus($sformatf("simul%0d", c), 1'b0, 3'd3, 2'd2, 16'hBEEF, 1'b1,
                          (c < 4) ? 16'hFFFF : 16'h0000, 1'b1);
        end
        // Opcode change mid-blink must not restart the off phase.
        for (int c = 0; c < 4; c++) begin
            applyStimulus($sformatf("opChgBlink%0d", c), 1'b0, 3'd3, 2'd1, 16'hBEEF, 1'b1,
                          (c < 3) ? 16'h0000 : 16'hFFFF, 1'b1);
        end

        applyStimulus("errNonFinal", 1'b0, 3'd1, 2'd2, 16'hBEEF, 1'b1, 16'h0003, 1'b0);
        applyStimulus("blinkOn",     1'b0, 3'd3, 2'd2, 16'hBEEF, 1'b1, 16'hFFFF, 1'b1);

        #2;
        reset = 1'b1;
        sbQ.push_back('{name: "asyncReset", led: 16'h0000, blink: 1'b0, useB: 1'b0});
        #1;
        checkOutput();
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        reset        = 1'b0;
        busA.c_state = 2'd0;
        busA.error   = 1'b0;
        applyStimulus("afterReset", 1'b0, 3'd0, 2'd2, 16'hBEEF, 1'b0, 16'h0001, 1'b0);

        applyStimulus("bFinalRes",  1'b1, 3'd5, 2'd3, 16'h0ABC, 1'b0, 16'h00BC, 1'b0);
        applyStimulus("bOutRange7", 1'b1, 3'd7, 2'd3, 16'h0ABC, 1'b0, 16'h0000, 1'b0);
        applyStimulus("bState4",    1'b1, 3'd4, 2'd3, 16'h0ABC, 1'b0, 16'h001F, 1'b0);
        applyStimulus("bFinalBar",  1'b1, 3'd5, 2'd0, 16'h0ABC, 1'b0, 16'h003F, 1'b0);
        applyStimulus("bOutRange6", 1'b1, 3'd6, 2'd3, 16'h0ABC, 1'b0, 16'h0000, 1'b0);
        applyStimulus("bBlink",     1'b1, 3'd5, 2'd3, 16'h0ABC, 1'b1, 16'h00FF, 1'b1);
        applyStimulus("bOutErr",    1'b1, 3'd7, 2'd3, 16'h0ABC, 1'b1, 16'h0000, 1'b0);
        applyStimulus("bState0",    1'b1, 3'd0, 2'd3, 16'h0ABC, 1'b0, 16'h0001, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
